alu_mc: RTL
===========

Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the 8-bit datapath ALU.
- Adds the following:
  - generic WIDTH;
  - registered carry, shift-carry and compare flags that persist between instructions, for multi-precision chains;
  - barrel-free iterative shift-by-N;
  - iterative shift-add multiply;
  - start/busy/done handshake.
- Sits between the register file read ports and the writeback mux; the controller stalls the PC while busy=1.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- SHW, $clog2(WIDTH)+1, width of shift-amount input (allows shamt up to WIDTH).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  launch operation; sampled only in IDLE.
- Aluop  input  3  opcode.
- mode  input  2  sub-op for Aluop=101.
- DatA  input  WIDTH  operand A.
- DatB  input  WIDTH  operand B.
- shamt  input  SHW  shift amount for shift sub-ops.
- use_c  input  1  1: chain the stored flag (C for add/SRL, SC for SLL) into the operation.
- flag_clr  input  1  synchronous clear of C and SC flags; ignored while busy.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; Rslt/Rhi/flags valid from this cycle.
- Rslt  output  WIDTH  result (MUL: low half).
- Rhi  output  WIDTH  MUL high half; 0 for other ops.
- Co  output  1  stored carry flag.
- SCo  output  1  stored shift-carry flag.
- gt  output  1  stored unsigned A>B flag.
- eq  output  1  stored A==B flag.

Behaviour:
- Reset: state=IDLE, all outputs 0 (busy, done, Rslt, Rhi, Co, SCo, gt, eq). Reset mid-operation aborts the op with no partial result or flag update.
- States are IDLE, EXEC, SHIFT, MUL.
- IDLE, start=1: latch Aluop, mode, DatA, DatB, shamt, use_c. busy=1 from the next cycle. Next state per op:
  - single-cycle ops go to EXEC;
  - shifts with shamt>0 go to SHIFT;
  - MUL goes to MUL.
- start while busy is ignored, with no queueing.
- EXEC (latency 1, so done is asserted the cycle after start):
  - 000 ADD: {C,Rslt} = A+B+(use_c?C:0). gt=(A>B) and eq=(A==B), unsigned on the original operands.
  - 001 XOR: Rslt=A^B. Flags unchanged.
  - 010 CLR: Rslt=0. Flags unchanged.
  - 110 CMP: Rslt=0. gt/eq updated as for ADD; C and SC unchanged.
  - 101 mode 01 NEG: Rslt=~A+1. C=1 iff A==0.
  - 101 shift sub-op with shamt=0: Rslt=A, SC unchanged.
  - 100, 111: Rslt=0, no flag change.
- SHIFT (101, mode 00/10/11) runs one bit per cycle for shamt cycles. Done is asserted the cycle after the last shift, so latency = shamt+1.
  - mode 00 SLL: shifts left. Fill bit = (use_c?SC:0) on the first step only, 0 on later steps. SC = last bit shifted out of MSB.
  - mode 10 SRL: shifts right. Fill = (use_c?C:0) on the first step only, 0 on later steps. SC = last bit shifted out of LSB.
  - mode 11 SRA: sign fill on every step. SC = last LSB out.
  - shamt>=WIDTH is legal. SLL/SRL give 0 (plus the first fill bit if it is still in range); SRA gives all sign bits.
- MUL (011): unsigned shift-add over exactly WIDTH cycles; latency WIDTH+1. {Rhi,Rslt} = A*B. C = (Rhi!=0). Other flags unchanged.
- done: high exactly one cycle, coincident with busy falling to 0. The state returns to IDLE in that cycle, and start is accepted again the next cycle (back-to-back issue, no bubble beyond done).
- Rslt/Rhi hold their values until the next done. Flags hold until an op updates them, flag_clr, or Reset.
- flag_clr together with start in IDLE: the clear applies first, so the launched op sees C=SC=0.

Test Plan:
- WIDTH=8 chaining:
  - ADD DatA=0xFF, DatB=0x01, use_c=0 -> done 1 cycle later, Rslt=0x00, Co=1, gt=1, eq=0.
  - Then ADD 0x00+0x00, use_c=1 -> Rslt=0x01, Co=0.
- SLL A=0x81, shamt=3, use_c=1 with SC=1 -> busy 3 cycles, done at cycle 4, Rslt=0x0C, SCo=0 (bits out in order 1,0,0).
- SRA A=0x80, shamt=9 -> Rslt=0xFF, SCo=1.
- SRL A=0x01, shamt=1, use_c=1 with C=1 -> Rslt=0x80, SCo=1.
- MUL A=0xFF, B=0xFF -> done exactly 9 cycles after start, Rhi=0xFE, Rslt=0x01, Co=1.
- Further cases:
  - start pulsed during a MUL -> ignored, original result intact.
  - Reset asserted at cycle 4 of a MUL -> busy=0, Rslt=0, Co=0 immediately; no done pulse.
  - NEG A=0x00 -> Rslt=0x00, Co=1.
  - WIDTH=16 ADD 0xFFFF+0x0001 -> Rslt=0x0000, Co=1.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a start/busy/done handshake and flags that
// persist between instructions so carries can be chained across words.
// Single-cycle ops resolve on the launch edge. Shifts step one bit per cycle,
// and MUL is an unsigned shift-add over WIDTH cycles.
module alu_mc #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [2:0]       Aluop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] DatA,
  input  logic [WIDTH-1:0] DatB,
  input  logic [SHW-1:0]   shamt,
  input  logic             use_c,
  input  logic             flag_clr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Rslt,
  output logic [WIDTH-1:0] Rhi,
  output logic             Co,
  output logic             SCo,
  output logic             gt,
  output logic             eq
);

  // state   | meaning
  // IDLE    | waiting for start; also the cycle in which done pulses
  // EXEC    | single-cycle ops; evaluated on the launch edge, no cycle spent here
  // SHIFT   | one bit of SLL/SRL/SRA per cycle, cnt_q steps left
  // MUL     | one shift-add step per cycle, cnt_q steps left
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT, S_MUL} state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SHF = 3'b101;
  localparam logic [2:0] OP_CMP = 3'b110;

  localparam logic [1:0] M_SLL = 2'b00;
  localparam logic [1:0] M_NEG = 2'b01;
  localparam logic [1:0] M_SRA = 2'b11;

  state_t state_q, state_d;

  logic [WIDTH-1:0] work_q, work_d;    // shift operand, or MUL multiplier/low product
  logic [WIDTH-1:0] mcand_q, mcand_d;  // MUL multiplicand
  logic [WIDTH-1:0] hi_q, hi_d;        // MUL running high half
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             fill_q, fill_d;    // fill bit for the next shift step (first step only)

  logic [WIDTH-1:0] rslt_q, rslt_d;
  logic [WIDTH-1:0] rhi_q, rhi_d;
  logic             c_q, c_d;
  logic             sc_q, sc_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             done_q, done_d;

  logic             is_mul, is_shift, last_step;
  logic             c_cur, sc_cur;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] shf_next;
  logic             shf_out;

  assign is_mul    = (Aluop == OP_MUL);
  assign is_shift  = (Aluop == OP_SHF) && (mode != M_NEG) && (shamt != '0);
  assign last_step = (cnt_q == SHW'(1));

  // flag_clr takes effect before a same-cycle launch sees the flags
  assign c_cur  = (flag_clr && state_q == S_IDLE) ? 1'b0 : c_q;
  assign sc_cur = (flag_clr && state_q == S_IDLE) ? 1'b0 : sc_q;

  assign add_sum = {1'b0, DatA} + {1'b0, DatB} + (WIDTH+1)'(use_c & c_cur);
  assign mul_sum = {1'b0, hi_q} + (work_q[0] ? {1'b0, mcand_q} : '0);

  // state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state: multi-cycle ops leave IDLE, everything else completes in place
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_mul)        state_d = S_MUL;
          else if (is_shift) state_d = S_SHIFT;
        end
      end
      S_SHIFT, S_MUL: if (last_step) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // handshake outputs
  always_comb begin
    busy = (state_q == S_SHIFT) || (state_q == S_MUL);
    done = done_q;
  end

  assign Rslt = rslt_q;
  assign Rhi  = rhi_q;
  assign Co   = c_q;
  assign SCo  = sc_q;
  assign gt   = gt_q;
  assign eq   = eq_q;

  // one shift step; SRL and SRA shift right, and SRA replicates the sign bit
  always_comb begin
    shf_out  = work_q[0];
    shf_next = {fill_q, work_q[WIDTH-1:1]};
    case (mode_q)
      M_SLL: begin
        shf_out  = work_q[WIDTH-1];
        shf_next = {work_q[WIDTH-2:0], fill_q};
      end
      M_SRA:   shf_next = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: ;
    endcase
  end

  // datapath next-state: launch, shift/multiply steps, and result publication
  always_comb begin
    work_d  = work_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    rslt_d  = rslt_q;
    rhi_d   = rhi_q;
    c_d     = c_cur;
    sc_d    = sc_cur;
    gt_d    = gt_q;
    eq_d    = eq_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          mcand_d = DatA;
          hi_d    = '0;
          work_d  = is_mul ? DatB : DatA;
          cnt_d   = is_mul ? SHW'(WIDTH) : shamt;
          fill_d  = use_c & ((mode == M_SLL) ? sc_cur : c_cur);
          if (!is_mul && !is_shift) begin
            done_d = 1'b1;
            rhi_d  = '0;
            case (Aluop)
              OP_ADD: begin
                rslt_d = add_sum[WIDTH-1:0];
                c_d    = add_sum[WIDTH];
                gt_d   = (DatA > DatB);
                eq_d   = (DatA == DatB);
              end
              OP_XOR: rslt_d = DatA ^ DatB;
              OP_CMP: begin
                rslt_d = '0;
                gt_d   = (DatA > DatB);
                eq_d   = (DatA == DatB);
              end
              OP_SHF: begin
                if (mode == M_NEG) begin
                  rslt_d = ~DatA + WIDTH'(1);
                  c_d    = (DatA == '0);
                end else begin
                  rslt_d = DatA;
                end
              end
              default: rslt_d = '0;
            endcase
          end
        end
      end
      S_SHIFT: begin
        work_d = shf_next;
        fill_d = 1'b0;
        cnt_d  = cnt_q - SHW'(1);
        if (last_step) begin
          rslt_d = shf_next;
          rhi_d  = '0;
          sc_d   = shf_out;
          done_d = 1'b1;
        end
      end
      S_MUL: begin
        hi_d   = mul_sum[WIDTH:1];
        work_d = {mul_sum[0], work_q[WIDTH-1:1]};
        cnt_d  = cnt_q - SHW'(1);
        if (last_step) begin
          rslt_d = {mul_sum[0], work_q[WIDTH-1:1]};
          rhi_d  = mul_sum[WIDTH:1];
          c_d    = |mul_sum[WIDTH:1];
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // datapath and flag registers; reset discards any operation in flight
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      work_q  <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      fill_q  <= 1'b0;
      rslt_q  <= '0;
      rhi_q   <= '0;
      c_q     <= 1'b0;
      sc_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      work_q  <= work_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      rslt_q  <= rslt_d;
      rhi_q   <= rhi_d;
      c_q     <= c_d;
      sc_q    <= sc_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      done_q  <= done_d;
    end
  end

endmodule
